// File: rtl/debug_unit_receive_pkg.sv
// rtl/debug_unit_receive_pkg.sv - shared encodings and command bytes for the debug unit receiver
package debug_unit_receive_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_MODE = 3'd2,
        ST_RUN_CONT  = 3'd3,
        ST_RUN_STEP  = 3'd4
    } state_t;

    localparam logic [7:0]  CMD_LOAD  = 8'h55;
    localparam logic [7:0]  CMD_STEP  = 8'h01;
    localparam logic [7:0]  MODE_STEP = 8'h01;
    localparam logic [7:0]  MODE_CONT = 8'h00;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_unit_receive_assembler.sv
// rtl/debug_unit_receive_assembler.sv - packs four UART bytes into one word, MSB byte first
module byte_to_word_assembler #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_complete
);

    logic [NB_DATA-1:0] word_q;
    logic [1:0]         count_q;

    // o_word already includes the byte being shifted this cycle, so the
    // completed word is visible in the same cycle as the 4th strobe.
    assign o_word     = {word_q[NB_DATA-NB_BYTE-1:0], i_byte};
    assign o_complete = i_shift && (count_q == 2'd3);

    always_ff @(posedge i_clock) begin
        if (!i_reset || i_clear) begin
            word_q  <= '0;
            count_q <= 2'd0;
        end else if (i_shift) begin
            word_q  <= o_word;
            count_q <= count_q + 2'd1;
        end
    end

endmodule

// File: rtl/debug_unit_receive.sv
// rtl/debug_unit_receive.sv - UART command decoder: program load, execution mode and step pulses
module debug_unit_receive
    import debug_unit_receive_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_BYTE  = 8,
    parameter int NB_STATE = 3
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_done,
    output logic                o_execution_mode,
    output logic                o_execution_step,
    output logic                o_enable_write_memory,
    output logic                o_done_write_memory,
    output logic [NB_DATA-1:0]  o_data_memory,
    output logic [NB_STATE-1:0] o_state
);

    state_t             state_q;
    state_t             state_d;
    logic               asm_clear;
    logic               asm_shift;
    logic               asm_complete;
    logic [NB_DATA-1:0] asm_word;

    assign asm_clear = (state_q == ST_IDLE) && i_rx_done && (i_rx_data == CMD_LOAD);
    assign asm_shift = (state_q == ST_LOAD) && i_rx_done;

    byte_to_word_assembler #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_assembler (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (asm_clear),
        .i_shift    (asm_shift),
        .i_byte     (i_rx_data),
        .o_word     (asm_word),
        .o_complete (asm_complete)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q             <= ST_IDLE;
            o_done_write_memory <= 1'b0;
            o_execution_step    <= 1'b0;
            o_data_memory       <= '0;
        end else begin
            state_q             <= state_d;
            o_done_write_memory <= asm_complete;
            o_execution_step    <= (state_q == ST_RUN_STEP) && i_rx_done && (i_rx_data == CMD_STEP);
            if (asm_complete) begin
                o_data_memory <= asm_word;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_done && (i_rx_data == CMD_LOAD)) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (asm_complete && (asm_word == HALT_WORD)) state_d = ST_WAIT_MODE;
            end
            ST_WAIT_MODE: begin
                if (i_rx_done && (i_rx_data == MODE_STEP))      state_d = ST_RUN_STEP;
                else if (i_rx_done && (i_rx_data == MODE_CONT)) state_d = ST_RUN_CONT;
            end
            ST_RUN_CONT: state_d = ST_RUN_CONT;
            ST_RUN_STEP: state_d = ST_RUN_STEP;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Done is OR-ed in so the halt word still sees its write enable after leaving LOAD.
    always_comb begin
        o_enable_write_memory = (state_q == ST_LOAD) || o_done_write_memory;
        o_execution_mode      = (state_q == ST_RUN_STEP);
        o_state               = NB_STATE'(state_q);
    end

endmodule

// File: tb/tb_debug_unit_receive.sv
// tb/tb_debug_unit_receive.sv - randomized scoreboard bench for debug_unit_receive
module tb_debug_unit_receive;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        mode;
    logic        step;
    logic        en_wr;
    logic        done_wr;
    logic [31:0] data_mem;
    logic [2:0]  state;

    int total = 0;
    int bad = 0;

    int          m_state = 0;
    logic [7:0]  partial[$];
    logic [31:0] exp_words[$];
    int          exp_steps[$];

    always #5 clk = ~clk;

    debug_unit_receive dut (
        .i_clock               (clk),
        .i_reset               (rstn),
        .i_rx_data             (rx_data),
        .i_rx_done             (rx_done),
        .o_execution_mode      (mode),
        .o_execution_step      (step),
        .o_enable_write_memory (en_wr),
        .o_done_write_memory   (done_wr),
        .o_data_memory         (data_mem),
        .o_state               (state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every pulse the DUT presents must match the oldest expected event.
    always @(negedge clk) begin
        if (done_wr === 1'b1) begin
            total++;
            if (exp_words.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected: got pulse data %h expected no pulse", data_mem);
            end else begin
                logic [31:0] w;
                w = exp_words.pop_front();
                if (data_mem !== w) begin
                    bad++;
                    $display("FAIL done_data: got %h expected %h", data_mem, w);
                end
            end
        end
        if (step === 1'b1) begin
            total++;
            if (exp_steps.size() == 0) begin
                bad++;
                $display("FAIL step_unexpected: got pulse expected none");
            end else begin
                void'(exp_steps.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  nxt;
        bit  done_now;
        nxt = m_state;
        done_now = 0;
        case (m_state)
            0: if (b == 8'h55) begin nxt = 1; partial.delete(); end
            1: begin
                partial.push_back(b);
                if (partial.size() == 4) begin
                    logic [31:0] w;
                    w = (32'(partial[0]) << 24) | (32'(partial[1]) << 16) |
                        (32'(partial[2]) << 8)  | 32'(partial[3]);
                    exp_words.push_back(w);
                    partial.delete();
                    done_now = 1;
                    if (w == 32'hFFFF_FFFF) nxt = 2;
                end
            end
            2: if (b == 8'h01) nxt = 4; else if (b == 8'h00) nxt = 3;
            4: if (b == 8'h01) exp_steps.push_back(1);
            default: ;
        endcase
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        m_state = nxt;
        chk("state", 32'(state), 32'(m_state));
        chk("enable", 32'(en_wr), 32'(m_state == 1 || done_now));
        chk("mode", 32'(mode), 32'(m_state == 4));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8]);
            idle($urandom_range(max_gap, 0));
        end
    endtask

    task automatic do_reset();
        rx_done = 1'b0;
        rstn = 1'b0;
        idle(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", {26'd0, mode, step, en_wr, done_wr, 2'd0}, 32'd0);
        chk("rst_data", data_mem, 32'd0);
        rstn = 1'b1;
        m_state = 0;
        partial.delete();
        exp_words.delete();
        exp_steps.delete();
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  b;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            if (b == 8'h55) b = 8'h54;
            send_byte(b);
        end
        chk("idle_data", data_mem, 32'd0);

        send_byte(8'h55);
        send_word(32'hAABBCCDD, 0);
        send_word(32'h11223344, 0);
        send_word(32'h1F2F3F4F, 0);
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h0;
            send_word(w, 2);
        end
        idle(2);
        chk("load_stays", 32'(state), 32'd1);

        send_word(32'hFFFF_FFFF, 0);
        idle(1);
        chk("halt_en_off", 32'(en_wr), 32'd0);
        chk("halt_state", 32'(state), 32'd2);
        chk("halt_data", data_mem, 32'hFFFF_FFFF);

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(255, 2));
            send_byte(b);
        end
        send_byte(8'h01);
        idle(3);
        send_byte(8'h01);
        idle(1);
        send_byte(8'h01);
        for (int i = 0; i < 30; i++) begin
            b = ($urandom_range(1, 0) == 1) ? 8'h01 : 8'($urandom);
            send_byte(b);
            idle($urandom_range(2, 0));
        end
        idle(3);
        chk("steps_drained", 32'(exp_steps.size()), 32'd0);
        chk("words_drained", 32'(exp_words.size()), 32'd0);

        do_reset();
        send_byte(8'h55);
        send_byte(8'hDE);
        send_byte(8'hAD);
        do_reset();
        send_byte(8'h55);
        send_word(32'h12345678, 1);
        idle(1);
        chk("reload_data", data_mem, 32'h12345678);
        send_word(32'hFFFF_FFFF, 1);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h01);
            idle($urandom_range(1, 0));
        end
        idle(2);
        chk("cont_state", 32'(state), 32'd3);
        chk("cont_steps", 32'(exp_steps.size()), 32'd0);
        chk("cont_words", 32'(exp_words.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
